uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
Bus-master sequencer that owns the UART register bus.
- On start, it configures the UART: clears UE, writes BRR, then writes CR with UE and TCIE forced on.
- It then drains an internal byte FIFO into TDR, one byte per completed transmission.
- It sits between a CPU/DMA byte producer and the UART bus-slave register block, so software never has to poll the UART.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2.
TIMEOUT, 255, max cycles cs held low without ack before the transaction is abandoned.

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
start_i  in  1  one-cycle pulse: run the configuration sequence
cfg_brr_i  in  16  baud divisor, written to BRR
cfg_cr_i  in  6  CR value; bits 0 (UE) and 2 (TCIE) are forced to 1 on write
wr_en_i  in  1  push wr_data_i into the FIFO
wr_data_i  in  8  byte to transmit
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
ready_o  out  1  configuration done; transmit loop active
err_o  out  1  sticky: a bus timeout occurred; cleared by start_i
uart_cs_o  out  1  UART chip select, active-low
uart_we_o  out  1  1 = write, 0 = read
uart_adr_o  out  32  register address: SR=0x0, TDR=0x4, BRR=0x8, CR=0xC
uart_dat_o  out  32  write data
uart_dat_i  in  32  read data; valid while uart_ack_i=1
uart_ack_i  in  1  slave ack; stays high while cs is low, clears when cs is high

Behaviour:
- Reset (async assert, sync release): uart_cs_o=1, we/adr/dat=0, ready_o=0, err_o=0, FIFO emptied (empty_o=1, full_o=0, count_o=0), FSM=IDLE.
- Bus transaction: drive cs=0 with we/adr/dat stable until uart_ack_i is sampled 1.
  - Read data is captured on that same edge.
  - cs then goes high for exactly 1 gap cycle before any new transaction.
  - Minimum transaction = 2 cycles with cs low + 1 gap cycle.
- Timeout: a counter runs while cs=0 and ack=0.
  - At TIMEOUT: release cs, set err_o, return to WAIT_DATA.
  - The FIFO head is not popped, so the byte is retried.
- FSM:
  - IDLE: waits for start_i → CFG_CR0.
  - CFG_CR0: write CR=0 (UE must be 0 for BRR to latch) → CFG_BRR.
  - CFG_BRR: write BRR={16'b0,cfg_brr_i} → CFG_CR.
  - CFG_CR: write CR={26'b0,cfg_cr_i|6'b000101}; set ready_o → WAIT_DATA.
  - WAIT_DATA: waits for !empty → POLL_BUSY.
  - POLL_BUSY: read SR.
    - If SR[3] (busy)=1, re-read after the gap.
    - Otherwise → WR_TDR.
  - WR_TDR: write TDR={24'b0,fifo_head}; pop the FIFO on ack → POLL_TC.
  - POLL_TC: read SR repeatedly until SR[0] (TC)=1 → CLR_TC.
  - CLR_TC: write SR=32'hFFFF_FFFE; only TC is cleared, RC/PE are preserved → WAIT_DATA.
- start_i is honoured only in IDLE and WAIT_DATA.
  - It clears err_o and ready_o and restarts from CFG_CR0.
  - FIFO contents are kept.
  - In all other states start_i is ignored.
- FIFO:
  - Push when wr_en_i and !full. A push while full is dropped silently.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push data is readable as the head no earlier than 1 cycle after the push.
- Reset asserted mid-transaction forces cs=1 immediately (asynchronous); no partial write is retried.

Decomposition:
- uart_pkg: register address constants (ADR_SR/TDR/BRR/CR), SR bit indices (TC=0, RC=1, PE=2, BUSY=3), CR bit indices (UE=0, RCIE=1, TCIE=2, PEIE=3), FSM state enum.
- Sub-module uart_tx_fifo (parameter DEPTH): synchronous FIFO with count, full and empty.
- FSM, bus driver and timeout counter live in the top module.

Test Plan:
- Config: rst_n_i low then high; start_i with brr=0x01B2, cr=0x00 → bus writes, in order, CR@0xC=0x0, BRR@0x8=0x1B2, CR@0xC=0x5; ready_o=1; exactly one cs-high gap between writes.
- Single byte: push 0x41; slave model reports SR busy=0, then TC=1 after 10 reads → sequence is SR read, TDR write 0x41, SR polls, SR write 0xFFFF_FFFE; empty_o=1.
- Busy backpressure: SR[3]=1 for 5 reads, then 0 → no TDR write until the 6th SR read returns busy=0; then TDR write occurs.
- FIFO boundaries: push 9 bytes 0x00..0x08 with DEPTH=8 and the sequencer idle → full_o=1, count_o=8, 0x08 dropped; bytes 0x00..0x07 reach TDR in order.
- Timeout: slave never acks the TDR write → cs low for exactly 255 cycles, then released; err_o=1; the same byte is retried; a later start_i clears err_o.
- Reset mid-write: drop rst_n_i while cs=0 → uart_cs_o=1 with no clock edge; ready_o=0, count_o=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit sequencer: register map, SR/CR bit
// positions and the sequencer state encoding.
package uart_pkg;

  localparam logic [31:0] ADR_SR  = 32'h0;
  localparam logic [31:0] ADR_TDR = 32'h4;
  localparam logic [31:0] ADR_BRR = 32'h8;
  localparam logic [31:0] ADR_CR  = 32'hC;

  localparam int SR_TC   = 0;
  localparam int SR_RC   = 1;
  localparam int SR_PE   = 2;
  localparam int SR_BUSY = 3;

  localparam int CR_UE   = 0;
  localparam int CR_RCIE = 1;
  localparam int CR_TCIE = 2;
  localparam int CR_PEIE = 3;

  // UE and TCIE are always set when the final CR value is written.
  localparam logic [5:0] CR_FORCE = 6'((1 << CR_UE) | (1 << CR_TCIE));

  // Writing zero to TC clears it; ones leave RC/PE untouched.
  localparam logic [31:0] SR_CLR_TC = 32'hFFFF_FFFE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_CR0,
    ST_CFG_BRR,
    ST_CFG_CR,
    ST_WAIT_DATA,
    ST_POLL_BUSY,
    ST_WR_TDR,
    ST_POLL_TC,
    ST_CLR_TC
  } seq_state_e;

  // States that own a bus transaction.
  function automatic logic is_bus_state(input seq_state_e s);
    return !(s == ST_IDLE || s == ST_WAIT_DATA);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy count. The head is a combinational read
// of the storage array, so a pushed byte becomes visible after its write edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr_q];

  // A push into a full FIFO is dropped without any indication.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Bus master that configures the UART and then feeds it from a byte FIFO.
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   IDLE         | waiting for start_i
//   CFG_CR0      | write CR=0 so that BRR can latch
//   CFG_BRR      | write baud divisor
//   CFG_CR       | write CR with UE/TCIE forced; sets ready_o
//   WAIT_DATA    | transmit loop idle, waiting for a FIFO byte
//   POLL_BUSY    | read SR until BUSY is clear
//   WR_TDR       | write FIFO head to TDR, pop on ack
//   POLL_TC      | read SR until TC is set
//   CLR_TC       | write SR to clear TC only
//
// Every bus state launches its transaction on the edge after cs has been
// high for one cycle, which yields the single gap cycle between transfers.
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  input  logic [15:0]                   cfg_brr_i,
  input  logic [5:0]                    cfg_cr_i,
  input  logic                          wr_en_i,
  input  logic [7:0]                    wr_data_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          ready_o,
  output logic                          err_o,
  output logic                          uart_cs_o,
  output logic                          uart_we_o,
  output logic [31:0]                   uart_adr_o,
  output logic [31:0]                   uart_dat_o,
  input  logic [31:0]                   uart_dat_i,
  input  logic                          uart_ack_i
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // Down-counter reload: terminal count 0 is reached after TIMEOUT low cycles.
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  seq_state_e    state_q, state_d;
  logic          cs_q, cs_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_empty;
  logic          unused_dat;

  // Only BUSY and TC steer the sequencer.
  assign unused_dat = ^{uart_dat_i[31:SR_BUSY+1], uart_dat_i[SR_BUSY-1:SR_TC+1]};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (wr_en_i),
    .data_i  (wr_data_i),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (full_o),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  assign empty_o    = fifo_empty;
  assign ready_o    = ready_q;
  assign err_o      = err_q;
  assign uart_cs_o  = cs_q;
  assign uart_we_o  = we_q;
  assign uart_adr_o = adr_q;
  assign uart_dat_o = dat_q;

  // Next-state, bus launch/complete and timeout logic.
  always_comb begin
    state_d  = state_q;
    cs_d     = cs_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    ready_d  = ready_q;
    fifo_pop = 1'b0;

    if (!cs_q) begin
      if (uart_ack_i) begin
        cs_d = 1'b1;
        case (state_q)
          ST_CFG_CR0:   state_d = ST_CFG_BRR;
          ST_CFG_BRR:   state_d = ST_CFG_CR;
          ST_CFG_CR: begin
            state_d = ST_WAIT_DATA;
            ready_d = 1'b1;
          end
          ST_POLL_BUSY: if (!uart_dat_i[SR_BUSY]) state_d = ST_WR_TDR;
          ST_WR_TDR: begin
            state_d  = ST_POLL_TC;
            fifo_pop = 1'b1;
          end
          ST_POLL_TC:   if (uart_dat_i[SR_TC]) state_d = ST_CLR_TC;
          ST_CLR_TC:    state_d = ST_WAIT_DATA;
          default:      state_d = ST_IDLE;
        endcase
      end else if (tmr_q == '0) begin
        // Abandon the transfer; the FIFO head stays put and is retried.
        cs_d    = 1'b1;
        err_d   = 1'b1;
        state_d = ST_WAIT_DATA;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT_DATA: begin
          if (start_i) begin
            state_d = ST_CFG_CR0;
            err_d   = 1'b0;
            ready_d = 1'b0;
          end else if (state_q == ST_WAIT_DATA && !fifo_empty) begin
            state_d = ST_POLL_BUSY;
          end
        end
        default: state_d = state_q;
      endcase

      if (is_bus_state(state_d)) begin
        cs_d  = 1'b0;
        tmr_d = TMR_LOAD;
        case (state_d)
          ST_CFG_CR0: begin
            we_d  = 1'b1;
            adr_d = ADR_CR;
            dat_d = '0;
          end
          ST_CFG_BRR: begin
            we_d  = 1'b1;
            adr_d = ADR_BRR;
            dat_d = {16'b0, cfg_brr_i};
          end
          ST_CFG_CR: begin
            we_d  = 1'b1;
            adr_d = ADR_CR;
            dat_d = {26'b0, cfg_cr_i | CR_FORCE};
          end
          ST_WR_TDR: begin
            we_d  = 1'b1;
            adr_d = ADR_TDR;
            dat_d = {24'b0, fifo_head};
          end
          ST_CLR_TC: begin
            we_d  = 1'b1;
            adr_d = ADR_SR;
            dat_d = SR_CLR_TC;
          end
          default: begin
            we_d  = 1'b0;
            adr_d = ADR_SR;
            dat_d = '0;
          end
        endcase
      end
    end
  end

  // State and registered bus outputs; reset releases the bus immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cs_q    <= 1'b1;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: a UART slave model answers the bus, expected
// transactions are queued by the stimulus and compared by a bus monitor.
module tb_uart_tx_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [15:0] cfg_brr_i;
  logic [5:0]  cfg_cr_i;
  logic        wr_en_i;
  logic [7:0]  wr_data_i;
  logic        full_o;
  logic        empty_o;
  logic [3:0]  count_o;
  logic        ready_o;
  logic        err_o;
  logic        uart_cs_o;
  logic        uart_we_o;
  logic [31:0] uart_adr_o;
  logic [31:0] uart_dat_o;
  logic [31:0] uart_dat_i;
  logic        uart_ack_i;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Slave model configuration, written only by the stimulus.
  int   busy_reads = 0;
  int   tc_reads   = 1;
  logic noack_tdr  = 1'b0;

  // Slave model state.
  int   busy_seen;
  int   tc_seen;
  logic tx_pending;

  // Monitor controls.
  logic gap_chk   = 1'b0;
  logic have_prev = 1'b0;

  uart_tx_sequencer #(
    .FIFO_DEPTH (8),
    .TIMEOUT    (255)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .cfg_brr_i  (cfg_brr_i),
    .cfg_cr_i   (cfg_cr_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .ready_o    (ready_o),
    .err_o      (err_o),
    .uart_cs_o  (uart_cs_o),
    .uart_we_o  (uart_we_o),
    .uart_adr_o (uart_adr_o),
    .uart_dat_o (uart_dat_o),
    .uart_dat_i (uart_dat_i),
    .uart_ack_i (uart_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: registered ack one cycle after cs falls, held until cs rises.
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      uart_ack_i <= 1'b0;
      uart_dat_i <= '0;
      busy_seen  <= 0;
      tc_seen    <= 0;
      tx_pending <= 1'b0;
    end else if (uart_cs_o) begin
      uart_ack_i <= 1'b0;
    end else if (!uart_ack_i && !(noack_tdr && uart_we_o && uart_adr_o == 32'h4)) begin
      uart_ack_i <= 1'b1;
      if (!uart_we_o) begin
        if (tx_pending) begin
          uart_dat_i <= (tc_seen >= tc_reads) ? 32'h1 : 32'h0;
          tc_seen    <= tc_seen + 1;
        end else begin
          uart_dat_i <= (busy_seen < busy_reads) ? 32'h8 : 32'h0;
          busy_seen  <= busy_seen + 1;
        end
      end else if (uart_adr_o == 32'h4) begin
        tx_pending <= 1'b1;
        tc_seen    <= 0;
      end else if (uart_adr_o == 32'h0 && !uart_dat_o[0]) begin
        tx_pending <= 1'b0;
        busy_seen  <= 0;
      end
    end
  end

  // Monitor: compares each acknowledged transfer with the scoreboard queue.
  int   lowcnt  = 0;
  int   gap_cnt = 0;
  logic prev_cs = 1'b1;
  always @(negedge clk_i) begin
    txn_t e;
    if (!rst_n_i) begin
      lowcnt  = 0;
      gap_cnt = 0;
      prev_cs = 1'b1;
    end else begin
      if (!uart_cs_o) begin
        if (prev_cs) begin
          if (gap_chk && have_prev) check("gap_cycles", gap_cnt, 1);
          lowcnt = 0;
        end
        lowcnt++;
        if (uart_ack_i) begin
          check("cs_low_cycles", lowcnt, 2);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_txn: we=%0b adr=0x%08h dat=0x%08h, expected none", uart_we_o, uart_adr_o, uart_dat_o);
          end else begin
            e = exp_q.pop_front();
            check("txn_we", {31'b0, uart_we_o}, {31'b0, e.we});
            check("txn_adr", uart_adr_o, e.adr);
            if (e.we) check("txn_dat", uart_dat_o, e.dat);
          end
          if (gap_chk) have_prev = 1'b1;
          gap_cnt = 0;
        end
      end else begin
        gap_cnt++;
      end
      prev_cs = uart_cs_o;
    end
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic exp_wr(input logic [31:0] adr, input logic [31:0] dat);
    txn_t t;
    t.we = 1'b1; t.adr = adr; t.dat = dat;
    exp_q.push_back(t);
  endtask

  task automatic exp_rd();
    txn_t t;
    t.we = 1'b0; t.adr = 32'h0; t.dat = 32'h0;
    exp_q.push_back(t);
  endtask

  // One byte: SR polls through BUSY, TDR write, SR polls until TC, TC clear.
  task automatic exp_byte(input logic [7:0] b, input int nbusy, input int ntc);
    for (int i = 0; i <= nbusy; i++) exp_rd();
    exp_wr(32'h4, {24'b0, b});
    for (int i = 0; i <= ntc; i++) exp_rd();
    exp_wr(32'h0, 32'hFFFF_FFFE);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en_i   = 1'b1;
    wr_data_i = b;
    tick();
    wr_en_i   = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      tick();
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic wait_tdr_cs(input int limit);
    int n = 0;
    while (!(uart_cs_o == 1'b0 && uart_adr_o == 32'h4) && n < limit) begin
      tick();
      n++;
    end
    check("tdr_write_seen", {31'b0, uart_cs_o}, 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cs"},    {31'b0, uart_cs_o}, 32'h1);
    check({tag, "_we"},    {31'b0, uart_we_o}, 32'h0);
    check({tag, "_adr"},   uart_adr_o, 32'h0);
    check({tag, "_dat"},   uart_dat_o, 32'h0);
    check({tag, "_ready"}, {31'b0, ready_o}, 32'h0);
    check({tag, "_err"},   {31'b0, err_o}, 32'h0);
    check({tag, "_empty"}, {31'b0, empty_o}, 32'h1);
    check({tag, "_full"},  {31'b0, full_o}, 32'h0);
    check({tag, "_count"}, {28'b0, count_o}, 32'h0);
  endtask

  initial begin
    int n;
    rst_n_i   = 1'b0;
    start_i   = 1'b0;
    cfg_brr_i = 16'h01B2;
    cfg_cr_i  = 6'h00;
    wr_en_i   = 1'b0;
    wr_data_i = 8'h00;
    repeat (3) tick();
    check_reset_state("in_reset");
    rst_n_i = 1'b1;
    tick();
    check_reset_state("after_reset");

    // FIFO fill while idle: ninth byte is dropped.
    for (int i = 0; i < 9; i++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'(i);
      tick();
    end
    wr_en_i = 1'b0;
    check("fill_count", {28'b0, count_o}, 32'h8);
    check("fill_full",  {31'b0, full_o}, 32'h1);
    check("fill_empty", {31'b0, empty_o}, 32'h0);

    // Configuration followed by draining bytes 0x00..0x07 back to back.
    exp_wr(32'hC, 32'h0);
    exp_wr(32'h8, 32'h0000_01B2);
    exp_wr(32'hC, 32'h5);
    for (int i = 0; i < 8; i++) exp_byte(8'(i), 0, 1);
    busy_reads = 0;
    tc_reads   = 1;
    gap_chk    = 1'b1;
    have_prev  = 1'b0;
    pulse_start();
    wait_drain(2000);
    gap_chk = 1'b0;
    check("cfg_ready", {31'b0, ready_o}, 32'h1);
    check("drain_empty", {31'b0, empty_o}, 32'h1);
    check("drain_count", {28'b0, count_o}, 32'h0);
    check("drain_full", {31'b0, full_o}, 32'h0);
    check("drain_err", {31'b0, err_o}, 32'h0);

    // Single byte, TC after 10 polls.
    tc_reads = 10;
    exp_byte(8'h41, 0, 10);
    push_byte(8'h41);
    wait_drain(500);
    check("single_empty", {31'b0, empty_o}, 32'h1);

    // BUSY backpressure for 5 reads.
    tc_reads   = 1;
    busy_reads = 5;
    exp_byte(8'h5A, 5, 1);
    push_byte(8'h5A);
    wait_drain(500);
    busy_reads = 0;
    check("busy_empty", {31'b0, empty_o}, 32'h1);

    // Timeout on the TDR write, then a retry of the same byte.
    noack_tdr = 1'b1;
    exp_rd();
    exp_byte(8'hC3, 0, 1);
    push_byte(8'hC3);
    wait_tdr_cs(200);
    n = 0;
    while (uart_cs_o == 1'b0 && n < 1000) begin
      n++;
      tick();
    end
    check("timeout_cs_low_cycles", n, 255);
    check("timeout_err", {31'b0, err_o}, 32'h1);
    check("timeout_count", {28'b0, count_o}, 32'h1);
    noack_tdr = 1'b0;
    wait_drain(500);
    check("retry_err_sticky", {31'b0, err_o}, 32'h1);
    check("retry_empty", {31'b0, empty_o}, 32'h1);

    // Restart from WAIT_DATA clears err/ready and reconfigures.
    cfg_brr_i = 16'h0010;
    cfg_cr_i  = 6'h2A;
    exp_wr(32'hC, 32'h0);
    exp_wr(32'h8, 32'h0000_0010);
    exp_wr(32'hC, 32'h2F);
    pulse_start();
    check("restart_err", {31'b0, err_o}, 32'h0);
    check("restart_ready", {31'b0, ready_o}, 32'h0);
    wait_drain(200);
    check("restart_ready_done", {31'b0, ready_o}, 32'h1);

    // Reset asserted while the TDR write is pending.
    noack_tdr = 1'b1;
    exp_rd();
    push_byte(8'h77);
    wait_tdr_cs(200);
    tick();
    rst_n_i = 1'b0;
    #1;
    check("rst_mid_cs", {31'b0, uart_cs_o}, 32'h1);
    check("rst_mid_ready", {31'b0, ready_o}, 32'h0);
    check("rst_mid_count", {28'b0, count_o}, 32'h0);
    check("rst_mid_queue", exp_q.size(), 0);
    tick();
    tick();
    rst_n_i   = 1'b1;
    noack_tdr = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!uart_cs_o) n++;
      tick();
    end
    check("post_rst_no_retry", n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
